// File: rtl/qdec_pkg.sv
// Shared types for the quadrature decoder: FSM states, phase codes, step classes.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package qdec_pkg;

    typedef enum logic {
        QD_INIT  = 1'b0,
        QD_TRACK = 1'b1
    } qd_state_t;

    // Phase codes as {A,B}; the forward Gray order is 00 -> 01 -> 11 -> 10 -> 00.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_UP      = 2'd1,
        STEP_DOWN    = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_cls_t;

    // Position of a phase on the Gray ring, so neighbours differ by +/-1 mod 4.
    function automatic logic [1:0] ring_pos(input logic [1:0] ph);
        logic [1:0] pos;
        case (ph)
            PH_00:   pos = 2'd0;
            PH_01:   pos = 2'd1;
            PH_11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    // Classify a transition between two agreed phases.
    function automatic step_cls_t classify(input logic [1:0] old_ph, input logic [1:0] new_ph);
        logic [1:0] delta;
        step_cls_t  cls;
        delta = ring_pos(new_ph) - ring_pos(old_ph);
        case (delta)
            2'd1:    cls = STEP_UP;
            2'd3:    cls = STEP_DOWN;
            2'd2:    cls = STEP_ILLEGAL;
            default: cls = STEP_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// Synchronises the raw {A,B} pins and reports when FILTER_LEN consecutive samples agree.
// Latency: SYNC_STAGES + FILTER_LEN edges from first sampling edge to agreed_vld.
// Backpressure: none; free-running, agreed_vld is a level held while the window is uniform.
module qdec_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] raw_dat,
    output logic [1:0] agreed_dat,
    output logic       agreed_vld
);
    import qdec_pkg::*;

    localparam int FILL_LEN = SYNC_STAGES + FILTER_LEN;

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [FILTER_LEN-1:0][1:0]  filt_q;
    // Tracks which pipeline slots hold real samples rather than reset zeros, so
    // the cleared filter contents are never mistaken for an agreed 00 level.
    logic [FILL_LEN-1:0]         fill_q;
    logic                        all_eq;

    // Synchroniser chain, filter window and fill tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            filt_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q[0] <= raw_dat;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            filt_q[0] <= sync_q[SYNC_STAGES-1];
            for (int i = 1; i < FILTER_LEN; i++) begin
                filt_q[i] <= filt_q[i-1];
            end
            fill_q <= {fill_q[FILL_LEN-2:0], 1'b1};
        end
    end

    // Window is uniform when every entry matches the newest one.
    always_comb begin
        all_eq = 1'b1;
        for (int i = 1; i < FILTER_LEN; i++) begin
            if (filt_q[i] != filt_q[0]) all_eq = 1'b0;
        end
    end

    assign agreed_dat = filt_q[0];
    assign agreed_vld = fill_q[FILL_LEN-1] & all_eq;

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder with wrapping up/down position count and illegal-step detection.
// Latency: SYNC_STAGES + FILTER_LEN + 1 edges from first sampling edge to count/step update.
// Backpressure: none; every accepted step is reported as a one-cycle pulse.
module quad_decoder_counter
    import qdec_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             err_sticky,
    output logic             locked
);

    logic [1:0] agreed_dat;
    logic       agreed_vld;
    logic [1:0] phase_q;
    qd_state_t  state_q;
    qd_state_t  state_nxt;
    logic       capture;
    step_cls_t  cls;

    qdec_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .clk        (clk),
        .rst        (rst),
        .raw_dat    ({a_in, b_in}),
        .agreed_dat (agreed_dat),
        .agreed_vld (agreed_vld)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= QD_INIT;
        else     state_q <= state_nxt;
    end

    // Next state, phase capture and classification of the agreed level.
    always_comb begin
        state_nxt = state_q;
        capture   = 1'b0;
        cls       = STEP_NONE;
        case (state_q)
            QD_INIT: begin
                // First stable level is only a reference; it never counts.
                if (agreed_vld) begin
                    capture   = 1'b1;
                    state_nxt = QD_TRACK;
                end
            end
            QD_TRACK: begin
                if (agreed_vld && (agreed_dat != phase_q)) begin
                    capture = 1'b1;
                    cls     = classify(phase_q, agreed_dat);
                end
            end
            default: state_nxt = QD_INIT;
        endcase
    end

    // Registered phase, count and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_00;
            count      <= '0;
            dir        <= 1'b1;
            step       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            locked     <= 1'b0;
        end else begin
            // Illegal jumps also resync the phase to the new level.
            if (capture) phase_q <= agreed_dat;
            step   <= (cls == STEP_UP) || (cls == STEP_DOWN);
            err    <= (cls == STEP_ILLEGAL);
            locked <= (state_q == QD_TRACK);
            if (cls == STEP_UP)        dir <= 1'b1;
            else if (cls == STEP_DOWN) dir <= 1'b0;
            // A new error wins over a simultaneous clear.
            if (cls == STEP_ILLEGAL) err_sticky <= 1'b1;
            else if (clr_err)        err_sticky <= 1'b0;
            // Load overrides any step; enable only gates the count itself.
            if (load)                               count <= load_val;
            else if (enable && (cls == STEP_UP))    count <= count + WIDTH'(1);
            else if (enable && (cls == STEP_DOWN))  count <= count - WIDTH'(1);
        end
    end

endmodule
